// File: rtl/dec_enc_pkg.sv
// Shared types and helpers for the request encoder queue and its dec3to8 counterpart.
package dec_enc_pkg;

  localparam int unsigned N = 8;
  localparam int unsigned W = $clog2(N);

  typedef enum logic [0:0] {
    IDLE,
    PRESENT
  } state_t;

  // Expands a binary code back into a single-bit request mask.
  function automatic logic [N-1:0] onehot(input logic [W-1:0] code);
    logic [N-1:0] mask;
    mask       = '0;
    mask[code] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/pri_enc_comb.sv
// Combinational N-to-W priority encoder; output is zero when no input bit is set.
module pri_enc_comb #(
  parameter int unsigned N         = 8,
  parameter int unsigned W         = $clog2(N),
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] code_o
);

  // Later matches in loop order override earlier ones, so the scan direction sets priority.
  always_comb begin
    code_o = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < N; i++) begin
        if (req_i[i]) code_o = W'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req_i[i]) code_o = W'(i);
      end
    end
  end

endmodule

// File: rtl/enc8to3_req_queue.sv
// Latches request pulses into a pending mask and presents them one at a time as a binary
// code with a valid/ack handshake, in fixed priority order.
module enc8to3_req_queue
  import dec_enc_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] Din,
  input  logic         ack,
  output logic [W-1:0] Y,
  output logic         valid,
  output logic [N-1:0] pend,
  output logic         drop
);

  state_t       state_q;
  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] y_q;
  logic         valid_q;
  logic         drop_q, drop_d;
  logic [N-1:0] set, clr;
  logic [W-1:0] next_code;

  always_comb begin
    set    = en ? Din : '0;
    clr    = (valid_q && ack) ? onehot(y_q) : '0;
    // Set wins: a re-request on the bit being acked stays pending.
    pend_d = (pend_q & ~clr) | set;
    drop_d = drop_q | (|(set & pend_q & ~clr));
  end

  pri_enc_comb #(
    .N         (N),
    .W         (W),
    .MSB_FIRST (MSB_FIRST)
  ) u_pri_enc (
    .req_i  (pend_d),
    .code_o (next_code)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      drop_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|pend_d) begin
            y_q     <= next_code;
            valid_q <= 1'b1;
            state_q <= PRESENT;
          end
        end
        PRESENT: begin
          // Y is held until acked; higher-priority arrivals wait their turn.
          if (ack) begin
            if (|pend_d) begin
              y_q <= next_code;
            end else begin
              y_q     <= '0;
              valid_q <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          y_q     <= '0;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Y     = y_q;
  assign valid = valid_q;
  assign pend  = pend_q;
  assign drop  = drop_q;

endmodule

// File: tb/tb_enc8to3_req_queue.sv
// Scoreboard bench for enc8to3_req_queue: expected codes are queued as requests are driven
// and compared at each accepted handshake; a second instance covers LSB-first priority.
module tb_enc8to3_req_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, ack = 1'b0;
  logic [7:0] din = '0;
  logic [2:0] y;
  logic       valid, drop;
  logic [7:0] pend;

  logic       en_l = 1'b0, ack_l = 1'b0;
  logic [7:0] din_l = '0;
  logic [2:0] y_l;
  logic       valid_l, drop_l;
  logic [7:0] pend_l;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [2:0]  sb_q[$];

  always #5 clk = ~clk;

  enc8to3_req_queue #(.MSB_FIRST(1'b1)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .Din   (din),
    .ack   (ack),
    .Y     (y),
    .valid (valid),
    .pend  (pend),
    .drop  (drop)
  );

  enc8to3_req_queue #(.MSB_FIRST(1'b0)) u_dut_lsb (
    .clk   (clk),
    .rst   (rst),
    .en    (en_l),
    .Din   (din_l),
    .ack   (ack_l),
    .Y     (y_l),
    .valid (valid_l),
    .pend  (pend_l),
    .drop  (drop_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Called #1 after an edge; drives inputs, scores any handshake, advances one cycle.
  task automatic step(input logic e, input logic [7:0] d, input logic a);
    en  = e;
    din = d;
    ack = a;
    if (a && valid) begin
      if (sb_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else check("hs_y", {29'd0, y}, {29'd0, sb_q.pop_front()});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [2:0] yy,
                            input logic [7:0] p, input logic dr);
    check({tag, "_valid"}, {31'd0, valid}, {31'd0, v});
    check({tag, "_y"}, {29'd0, y}, {29'd0, yy});
    check({tag, "_pend"}, {24'd0, pend}, {24'd0, p});
    check({tag, "_drop"}, {31'd0, drop}, {31'd0, dr});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    expect_out("reset", 1'b0, 3'd0, 8'h00, 1'b0);

    // Two simultaneous requests, served high bit first.
    sb_q.push_back(3'd5);
    sb_q.push_back(3'd2);
    step(1'b1, 8'b0010_0100, 1'b0);
    expect_out("t2_first", 1'b1, 3'd5, 8'h24, 1'b0);
    step(1'b1, 8'h00, 1'b1);
    expect_out("t2_second", 1'b1, 3'd2, 8'h04, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    expect_out("t2_empty", 1'b0, 3'd0, 8'h00, 1'b0);

    // Higher-priority arrival does not preempt an unacked code.
    sb_q.push_back(3'd2);
    sb_q.push_back(3'd7);
    step(1'b1, 8'h04, 1'b0);
    step(1'b1, 8'h80, 1'b0);
    expect_out("t3_hold", 1'b1, 3'd2, 8'h84, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    expect_out("t3_next", 1'b1, 3'd7, 8'h80, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check("t3_done_valid", {31'd0, valid}, 32'd0);

    // Re-request on the bit being acked stays pending without a drop.
    sb_q.push_back(3'd3);
    sb_q.push_back(3'd3);
    step(1'b1, 8'h08, 1'b0);
    step(1'b1, 8'h08, 1'b1);
    expect_out("t4_rereq", 1'b1, 3'd3, 8'h08, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    expect_out("t4_done", 1'b0, 3'd0, 8'h00, 1'b0);

    // Duplicate request on a pending, unacked bit sets sticky drop.
    sb_q.push_back(3'd6);
    step(1'b1, 8'h40, 1'b0);
    check("t5_pre_drop", {31'd0, drop}, 32'd0);
    step(1'b1, 8'h40, 1'b0);
    expect_out("t5_drop", 1'b1, 3'd6, 8'h40, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    expect_out("t5_sticky", 1'b0, 3'd0, 8'h00, 1'b1);

    // en=0 ignores Din but the presented code still drains.
    sb_q.push_back(3'd1);
    step(1'b1, 8'h02, 1'b0);
    step(1'b0, 8'hFF, 1'b0);
    expect_out("t6_en0", 1'b1, 3'd1, 8'h02, 1'b1);
    step(1'b0, 8'hFF, 1'b1);
    expect_out("t6_drain", 1'b0, 3'd0, 8'h00, 1'b1);

    // LSB-first instance: bit 0 served before bit 7.
    en_l  = 1'b1;
    din_l = 8'b1000_0001;
    @(posedge clk);
    #1;
    check("lsb_first_y", {29'd0, y_l}, 32'd0);
    check("lsb_first_valid", {31'd0, valid_l}, 32'd1);
    check("lsb_pend", {24'd0, pend_l}, 32'h81);
    en_l  = 1'b0;
    din_l = '0;
    ack_l = 1'b1;
    @(posedge clk);
    #1;
    check("lsb_second_y", {29'd0, y_l}, 32'd7);
    @(posedge clk);
    #1;
    ack_l = 1'b0;
    check("lsb_done_valid", {31'd0, valid_l}, 32'd0);

    // Asynchronous reset mid-handshake, with drop already set.
    step(1'b1, 8'h20, 1'b0);
    expect_out("t1_pre", 1'b1, 3'd5, 8'h20, 1'b1);
    en  = 1'b0;
    din = '0;
    #2;
    rst = 1'b1;
    #1;
    expect_out("t1_async", 1'b0, 3'd0, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_out("t1_after", 1'b0, 3'd0, 8'h00, 1'b0);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
